// File: rtl/deglitch_edge.sv
// Debounces a synchronized level and emits registered edge pulses.
// A saturating counter tallies the edges selected by cnt_sel.
module deglitch_edge #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din_sync,
    input  logic             en,
    input  logic [1:0]       cnt_sel,
    input  logic             clr,
    output logic             dout_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             evt_ovf
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOW   = 2'b00,
        CHK_HIGH = 2'b01,
        ST_HIGH  = 2'b11,
        CHK_LOW  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               rise_pulse_q, rise_pulse_d;
    logic               fall_pulse_q, fall_pulse_d;
    logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic               evt_ovf_q, evt_ovf_d;
    logic               counted;

    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        rise_pulse_d = 1'b0;
        fall_pulse_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (en && din_sync) begin
                    if (DEB_CYCLES == 1) begin
                        state_d      = ST_HIGH;
                        rise_pulse_d = 1'b1;
                    end else begin
                        state_d   = CHK_HIGH;
                        deb_cnt_d = DEB_W'(1);
                    end
                end
            end
            CHK_HIGH: begin
                // Disable or a single low sample rejects the pending rise.
                if (!en || !din_sync) begin
                    state_d   = ST_LOW;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = ST_HIGH;
                    deb_cnt_d    = '0;
                    rise_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_HIGH: begin
                if (en && !din_sync) begin
                    if (DEB_CYCLES == 1) begin
                        state_d      = ST_LOW;
                        fall_pulse_d = 1'b1;
                    end else begin
                        state_d   = CHK_LOW;
                        deb_cnt_d = DEB_W'(1);
                    end
                end
            end
            CHK_LOW: begin
                if (!en || din_sync) begin
                    state_d   = ST_HIGH;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = ST_LOW;
                    deb_cnt_d    = '0;
                    fall_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = ST_LOW;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Clear takes effect before the count, so a coincident pulse lands as 1.
    always_comb begin
        counted   = (rise_pulse_q & cnt_sel[0]) | (fall_pulse_q & cnt_sel[1]);
        evt_cnt_d = evt_cnt_q;
        evt_ovf_d = evt_ovf_q;
        if (clr) begin
            evt_cnt_d = counted ? CNT_W'(1) : '0;
            evt_ovf_d = 1'b0;
        end else if (counted) begin
            if (evt_cnt_q == CNT_MAX) begin
                evt_ovf_d = 1'b1;
            end else begin
                evt_cnt_d = evt_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_LOW;
            deb_cnt_q    <= '0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            evt_cnt_q    <= '0;
            evt_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            evt_cnt_q    <= evt_cnt_d;
            evt_ovf_q    <= evt_ovf_d;
        end
    end

    assign dout_stable = (state_q == ST_HIGH) || (state_q == CHK_LOW);
    assign rise_pulse  = rise_pulse_q;
    assign fall_pulse  = fall_pulse_q;
    assign evt_cnt     = evt_cnt_q;
    assign evt_ovf     = evt_ovf_q;

endmodule

// File: tb/tb_deglitch_edge.sv
// Drives three differently parameterized deglitch_edge instances from shared inputs
// and compares each against a run-length model of the debounce and edge counting.
module tb_deglitch_edge;

    localparam int N = 3;
    localparam int DEB[N]  = '{4, 4, 1};
    localparam int CNTW[N] = '{8, 2, 8};

    logic       clk = 1'b0;
    logic       rstn;
    logic       din_sync;
    logic       en;
    logic [1:0] cnt_sel;
    logic       clr;

    logic       dout_a, rise_a, fall_a, ovf_a;
    logic [7:0] cnt_a;
    logic       dout_b, rise_b, fall_b, ovf_b;
    logic [1:0] cnt_b;
    logic       dout_c, rise_c, fall_c, ovf_c;
    logic [7:0] cnt_c;

    logic        obs_dout[N];
    logic        obs_rise[N];
    logic        obs_fall[N];
    logic        obs_ovf[N];
    logic [31:0] obs_cnt[N];

    int checks   = 0;
    int failures = 0;

    bit m_stable[N];
    bit m_rise[N];
    bit m_fall[N];
    bit m_ovf[N];
    int m_run[N];
    int m_cnt[N];

    always #5 clk = ~clk;

    deglitch_edge #(.DEB_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .din_sync(din_sync), .en(en), .cnt_sel(cnt_sel), .clr(clr),
        .dout_stable(dout_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_cnt(cnt_a), .evt_ovf(ovf_a)
    );
    deglitch_edge #(.DEB_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .din_sync(din_sync), .en(en), .cnt_sel(cnt_sel), .clr(clr),
        .dout_stable(dout_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_cnt(cnt_b), .evt_ovf(ovf_b)
    );
    deglitch_edge #(.DEB_CYCLES(1), .CNT_W(8)) dut_c (
        .clk(clk), .rstn(rstn), .din_sync(din_sync), .en(en), .cnt_sel(cnt_sel), .clr(clr),
        .dout_stable(dout_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .evt_cnt(cnt_c), .evt_ovf(ovf_c)
    );

    assign obs_dout[0] = dout_a;
    assign obs_dout[1] = dout_b;
    assign obs_dout[2] = dout_c;
    assign obs_rise[0] = rise_a;
    assign obs_rise[1] = rise_b;
    assign obs_rise[2] = rise_c;
    assign obs_fall[0] = fall_a;
    assign obs_fall[1] = fall_b;
    assign obs_fall[2] = fall_c;
    assign obs_ovf[0]  = ovf_a;
    assign obs_ovf[1]  = ovf_b;
    assign obs_ovf[2]  = ovf_c;
    assign obs_cnt[0]  = {24'd0, cnt_a};
    assign obs_cnt[1]  = {30'd0, cnt_b};
    assign obs_cnt[2]  = {24'd0, cnt_c};

    task automatic compareVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_stable[i] = 1'b0;
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_ovf[i]    = 1'b0;
            m_run[i]    = 0;
            m_cnt[i]    = 0;
        end
    endtask

    // Level is accepted once DEB consecutive enabled samples differ from it.
    task automatic modelStep();
        bit counted;
        int maxv;
        for (int i = 0; i < N; i++) begin
            maxv    = (1 << CNTW[i]) - 1;
            counted = (m_rise[i] && cnt_sel[0]) || (m_fall[i] && cnt_sel[1]);
            if (clr) begin
                m_cnt[i] = counted ? 1 : 0;
                m_ovf[i] = 1'b0;
            end else if (counted) begin
                if (m_cnt[i] == maxv) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (en && (din_sync != m_stable[i])) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= DEB[i]) begin
                    m_stable[i] = din_sync;
                    m_run[i]    = 0;
                    if (din_sync) m_rise[i] = 1'b1;
                    else m_fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < N; i++) begin
            compareVal($sformatf("%s.%0d.dout", tag, i), {31'd0, obs_dout[i]}, {31'd0, m_stable[i]});
            compareVal($sformatf("%s.%0d.rise", tag, i), {31'd0, obs_rise[i]}, {31'd0, m_rise[i]});
            compareVal($sformatf("%s.%0d.fall", tag, i), {31'd0, obs_fall[i]}, {31'd0, m_fall[i]});
            compareVal($sformatf("%s.%0d.cnt", tag, i), obs_cnt[i], m_cnt[i]);
            compareVal($sformatf("%s.%0d.ovf", tag, i), {31'd0, obs_ovf[i]}, {31'd0, m_ovf[i]});
        end
    endtask

    task automatic applyStimulus(input string tag, input logic d, input logic e,
                                 input logic [1:0] sel, input logic c);
        din_sync = d;
        en       = e;
        cnt_sel  = sel;
        clr      = c;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic       lvl;
        int         hold;
        logic [1:0] rsel;

        rstn     = 1'b0;
        din_sync = 1'b0;
        en       = 1'b0;
        cnt_sel  = 2'b00;
        clr      = 1'b0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        compareVal("reset.dout_a", {31'd0, dout_a}, 32'd0);
        compareVal("reset.cnt_a", {24'd0, cnt_a}, 32'd0);
        rstn = 1'b1;

        // Accepted rise with DEB=4, counted on rising edges.
        for (int k = 0; k < 3; k++) applyStimulus("rise_wait", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("rise.dout_a_before", {31'd0, dout_a}, 32'd0);
        applyStimulus("rise_accept", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("rise.dout_a", {31'd0, dout_a}, 32'd1);
        compareVal("rise.pulse_a", {31'd0, rise_a}, 32'd1);
        applyStimulus("rise_after", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("rise.pulse_a_gone", {31'd0, rise_a}, 32'd0);
        compareVal("rise.cnt_a", {24'd0, cnt_a}, 32'd1);

        // Return low, then a 3-cycle glitch that must be rejected.
        for (int k = 0; k < 5; k++) applyStimulus("fall", 1'b0, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus("glitch_hi", 1'b1, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus("glitch_lo", 1'b0, 1'b1, 2'b01, 1'b0);
        compareVal("glitch.dout_a", {31'd0, dout_a}, 32'd0);
        compareVal("glitch.cnt_a", {24'd0, cnt_a}, 32'd1);

        // Clear coincident with a counted rise pulse.
        for (int k = 0; k < 4; k++) applyStimulus("clr_rise", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("clr_rise.pulse_a", {31'd0, rise_a}, 32'd1);
        applyStimulus("clr_hit", 1'b1, 1'b1, 2'b01, 1'b1);
        compareVal("clr_hit.cnt_a", {24'd0, cnt_a}, 32'd1);
        compareVal("clr_hit.ovf_a", {31'd0, ovf_a}, 32'd0);

        // Enable dropped on the second CHK_HIGH cycle, then a full restart.
        for (int k = 0; k < 5; k++) applyStimulus("en_fall", 1'b0, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus("en_chk", 1'b1, 1'b1, 2'b01, 1'b0);
        applyStimulus("en_drop", 1'b1, 1'b0, 2'b01, 1'b0);
        applyStimulus("en_hold", 1'b1, 1'b0, 2'b01, 1'b0);
        compareVal("en_drop.dout_a", {31'd0, dout_a}, 32'd0);
        compareVal("en_drop.rise_a", {31'd0, rise_a}, 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus("en_restart", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("en_restart.dout_a_3", {31'd0, dout_a}, 32'd0);
        applyStimulus("en_restart4", 1'b1, 1'b1, 2'b01, 1'b0);
        compareVal("en_restart.dout_a_4", {31'd0, dout_a}, 32'd1);

        // Saturation of the 2-bit counter on instance b, then clear.
        applyStimulus("sat_prep", 1'b1, 1'b1, 2'b11, 1'b0);
        applyStimulus("sat_clr0", 1'b1, 1'b1, 2'b11, 1'b1);
        compareVal("sat_clr0.cnt_b", {30'd0, cnt_b}, 32'd0);
        for (int h = 0; h < 8; h++) begin
            lvl = (h % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 5; k++) applyStimulus("sat_toggle", lvl, 1'b1, 2'b11, 1'b0);
            if (h == 2) begin
                compareVal("sat3.cnt_b", {30'd0, cnt_b}, 32'd3);
                compareVal("sat3.ovf_b", {31'd0, ovf_b}, 32'd0);
            end
            if (h == 3) begin
                compareVal("sat4.cnt_b", {30'd0, cnt_b}, 32'd3);
                compareVal("sat4.ovf_b", {31'd0, ovf_b}, 32'd1);
            end
        end
        compareVal("sat_end.cnt_b", {30'd0, cnt_b}, 32'd3);
        applyStimulus("sat_clr", 1'b1, 1'b1, 2'b11, 1'b1);
        compareVal("sat_clr.cnt_b", {30'd0, cnt_b}, 32'd0);
        compareVal("sat_clr.ovf_b", {31'd0, ovf_b}, 32'd0);

        // Asynchronous reset on the third CHK_LOW cycle.
        for (int k = 0; k < 3; k++) applyStimulus("chk_low", 1'b0, 1'b1, 2'b11, 1'b0);
        rstn = 1'b0;
        #2;
        modelReset();
        checkOutput("async_rst");
        compareVal("async_rst.dout_a", {31'd0, dout_a}, 32'd0);
        compareVal("async_rst.cnt_a", {24'd0, cnt_a}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus("post_rst1", 1'b1, 1'b1, 2'b11, 1'b0);
        compareVal("post_rst.dout_c", {31'd0, dout_c}, 32'd1);
        compareVal("post_rst.dout_a_1", {31'd0, dout_a}, 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus("post_rst", 1'b1, 1'b1, 2'b11, 1'b0);
        compareVal("post_rst.dout_a_4", {31'd0, dout_a}, 32'd1);

        // Randomized runs of held levels with occasional disable, clear and select changes.
        rsel = 2'b11;
        for (int k = 0; k < 80; k++) begin
            hold = $urandom_range(1, 6);
            lvl  = 1'($urandom_range(0, 1));
            for (int j = 0; j < hold; j++)
                applyStimulus("random", lvl, ($urandom_range(0, 9) != 0),
                              rsel, ($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 5) == 0) rsel = 2'($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deglitch_edge.md
DEGLITCH_EDGE -- requirements
Module: deglitch_edge

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive differing samples required to accept a level change; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the event counter; legal range 1..32.
REQ-003 clk  input  1  block clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 din_sync  input  1  level already synchronized to clk by a 2-flop synchronizer; no further synchronization inside this block.
REQ-006 en  input  1  filter enable; low freezes the filter.
REQ-007 cnt_sel  input  2  edges counted: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 clr  input  1  synchronous clear of evt_cnt and evt_ovf.
REQ-009 dout_stable  output  1  debounced level.
REQ-010 rise_pulse  output  1  one-cycle pulse when dout_stable goes 0->1.
REQ-011 fall_pulse  output  1  one-cycle pulse when dout_stable goes 1->0.
REQ-012 evt_cnt  output  CNT_W  saturating count of selected edges.
REQ-013 evt_ovf  output  1  sticky flag: a selected edge occurred while evt_cnt was saturated.

Function
REQ-014 The block SHALL implement four states: ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW; dout_stable SHALL be 0 in ST_LOW/CHK_HIGH and 1 in ST_HIGH/CHK_LOW.
REQ-015 The debounce counter SHALL have width clog2(DEB_CYCLES+1) and count consecutive edges at which din_sync differs from dout_stable.
REQ-016 ST_LOW with en=1 and din_sync=1: go to CHK_HIGH with counter=1; if DEB_CYCLES=1, go directly to ST_HIGH instead.
REQ-017 CHK_HIGH with din_sync=1: increment counter; on the edge where it would reach DEB_CYCLES, go to ST_HIGH and clear counter.
REQ-018 CHK_HIGH with din_sync=0: return to ST_LOW and clear counter, with no pulse (glitch rejected).
REQ-019 ST_HIGH/CHK_LOW SHALL behave symmetrically to REQ-016..REQ-018 with din_sync=0 as the differing value.
REQ-020 Latency: dout_stable SHALL change on the DEB_CYCLES-th consecutive rising edge that samples the new din_sync value.
REQ-021 rise_pulse (fall_pulse) SHALL be registered and high for exactly the one cycle after the edge at which dout_stable became 1 (0), i.e. aligned with the first cycle of the new dout_stable value.
REQ-022 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-023 en=0: a CHK state SHALL return to its stable state with counter cleared; a stable state SHALL hold; no pulses SHALL be generated; evt_cnt and clr SHALL remain operational.
REQ-024 On a pulse matching cnt_sel: if evt_cnt < 2^CNT_W-1, increment evt_cnt; otherwise hold evt_cnt and set evt_ovf.
REQ-025 clr=1 with no counted pulse: evt_cnt=0, evt_ovf=0 on the next edge.
REQ-026 clr=1 coincident with a counted pulse: evt_cnt=1, evt_ovf=0 (clear first, then count).
REQ-027 A change of cnt_sel SHALL affect only pulses in the cycles after the change and SHALL not alter evt_cnt.
REQ-028 evt_cnt SHALL never wrap from its maximum to 0.

Reset
REQ-029 While rstn=0: state ST_LOW, debounce counter 0, dout_stable 0, rise_pulse 0, fall_pulse 0, evt_cnt 0, evt_ovf 0.
REQ-030 Reset asserted mid-debounce SHALL abort the check with no pulse; after release the filter SHALL restart from ST_LOW.
REQ-031 After rstn deasserts, din_sync=1 held SHALL produce dout_stable=1 on the DEB_CYCLES-th edge, following REQ-020.

Verification
REQ-032 DEB_CYCLES=4, cnt_sel=01: din_sync 0->1 held -> dout_stable=1 after the 4th sampling edge, rise_pulse high one cycle, evt_cnt=1.
REQ-033 DEB_CYCLES=4: din_sync high for 3 cycles, then low -> dout_stable stays 0, no pulse, evt_cnt unchanged.
REQ-034 CNT_W=2, cnt_sel=11, 4 full toggles -> evt_cnt stops at 3 after 3 accepted edges, evt_ovf=1 on the 4th; then clr -> evt_cnt=0, evt_ovf=0.
REQ-035 clr asserted in the same cycle as a counted rise_pulse -> evt_cnt=1, evt_ovf=0.
REQ-036 en dropped at the 2nd cycle of CHK_HIGH -> state returns to ST_LOW and no pulse occurs; en raised with din_sync=1 -> full 4-cycle debounce restarts.
REQ-037 rstn asserted at the 3rd cycle of CHK_LOW -> all outputs 0 immediately; DEB_CYCLES=1 after release with din_sync=1 -> dout_stable=1 on the first edge.
